// File: rtl/misc_alu_pkg.sv
// Shared definitions for the miscellaneous-ALU path: op encodings, flag bit
// positions in F, and the execution FSM state type.
package misc_alu_pkg;

  typedef enum logic [1:0] {
    OP_DAA = 2'b00,
    OP_CPL = 2'b01,
    OP_SCF = 2'b10,
    OP_CCF = 2'b11
  } op_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

endpackage

// File: rtl/misc_alu_if.sv
// Command/result bundle between the microcode sequencer (master) and the
// misc-ALU execution block (slave).
interface misc_alu_if;
  logic       i_Start;
  logic [1:0] i_Op;
  logic [7:0] i_A;
  logic [7:0] i_F;
  logic       o_Ready;
  logic       o_Done;
  logic       o_WriteA;
  logic       o_WriteF;
  logic [7:0] o_A;
  logic [7:0] o_F;

  modport master (
    output i_Start, i_Op, i_A, i_F,
    input  o_Ready, o_Done, o_WriteA, o_WriteF, o_A, o_F
  );

  modport slave (
    input  i_Start, i_Op, i_A, i_F,
    output o_Ready, o_Done, o_WriteA, o_WriteF, o_A, o_F
  );
endinterface

// File: rtl/misc_alu_daa_adjust.sv
// Combinational decimal-adjust of A after a BCD add (n=0) or subtract (n=1);
// returns the adjusted accumulator and the new carry.
module misc_alu_daa_adjust (
  input  logic [7:0] a,
  input  logic       n,
  input  logic       h,
  input  logic       c,
  output logic [7:0] a_adj,
  output logic       c_adj
);

  logic       hi_fix;
  logic       lo_fix;
  logic [7:0] corr;

  always_comb begin
    hi_fix = c;
    lo_fix = h;
    // After an add the digit ranges of the original A also force correction
    if (!n) begin
      hi_fix = c || (a > 8'h99);
      lo_fix = h || (a[3:0] > 4'd9);
    end
    corr  = {1'b0, hi_fix, hi_fix, 1'b0, 1'b0, lo_fix, lo_fix, 1'b0};
    a_adj = n ? (a - corr) : (a + corr);
    c_adj = hi_fix;
  end

endmodule

// File: rtl/misc_alu_exec.sv
// DAA/CPL/SCF/CCF execution: IDLE -> EXEC -> WRITE with registered A/F strobes.
// DAA adjust logic is built only when MISC_ALU_DAA_EN is defined.
module misc_alu_exec
  import misc_alu_pkg::*;
(
  input logic        i_Clk,
  input logic        i_Reset_n,
  misc_alu_if.slave  bus
);

  state_e     state;
  state_e     state_nxt;
  logic       load;

  op_e        op_p0;
  logic [7:0] a_p0;
  logic [7:0] f_p0;

  logic [7:0] a_res;
  logic [7:0] f_res;
  logic       wr_a;
  logic       wr_f;

  function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                            input logic h, input logic c);
    return {z, n, h, c, 4'b0000};
  endfunction

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_Start) begin
          load      = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_WRITE;
      ST_WRITE: begin
        load      = bus.i_Start;
        state_nxt = bus.i_Start ? ST_EXEC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.o_Ready = (state == ST_IDLE) || (state == ST_WRITE);

  // p0: operands captured with the accepted start
  always_ff @(posedge i_Clk) begin
    if (load) begin
      op_p0 <= op_e'(bus.i_Op);
      a_p0  <= bus.i_A;
      f_p0  <= bus.i_F;
    end
  end

`ifdef MISC_ALU_DAA_EN
  logic [7:0] daa_a;
  logic       daa_c;
  logic       unused_p0;

  misc_alu_daa_adjust u_daa (
    .a     (a_p0),
    .n     (f_p0[FLAG_N]),
    .h     (f_p0[FLAG_H]),
    .c     (f_p0[FLAG_C]),
    .a_adj (daa_a),
    .c_adj (daa_c)
  );

  assign unused_p0 = ^{f_p0[3:0], bus.i_F[3:0]};
`else
  logic unused_p0;
  assign unused_p0 = ^{f_p0[3:0], f_p0[FLAG_H], bus.i_F[3:0]};
`endif

  always_comb begin
    a_res = a_p0;
    f_res = 8'h00;
    wr_a  = 1'b0;
    wr_f  = 1'b0;
    case (op_p0)
      OP_DAA: begin
`ifdef MISC_ALU_DAA_EN
        a_res = daa_a;
        f_res = pack_flags(daa_a == 8'h00, f_p0[FLAG_N], 1'b0, daa_c);
        wr_a  = 1'b1;
        wr_f  = 1'b1;
`endif
      end
      OP_CPL: begin
        a_res = ~a_p0;
        f_res = pack_flags(f_p0[FLAG_Z], 1'b1, 1'b1, f_p0[FLAG_C]);
        wr_a  = 1'b1;
        wr_f  = 1'b1;
      end
      OP_SCF: begin
        f_res = pack_flags(f_p0[FLAG_Z], 1'b0, 1'b0, 1'b1);
        wr_f  = 1'b1;
      end
      OP_CCF: begin
        f_res = pack_flags(f_p0[FLAG_Z], 1'b0, 1'b0, ~f_p0[FLAG_C]);
        wr_f  = 1'b1;
      end
      default: ;
    endcase
  end

  // p1: results registered at the end of EXEC, presented during WRITE
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      bus.o_Done   <= 1'b0;
      bus.o_WriteA <= 1'b0;
      bus.o_WriteF <= 1'b0;
      bus.o_A      <= 8'h00;
      bus.o_F      <= 8'h00;
    end else begin
      bus.o_Done   <= (state == ST_EXEC);
      bus.o_WriteA <= (state == ST_EXEC) && wr_a;
      bus.o_WriteF <= (state == ST_EXEC) && wr_f;
      if (state == ST_EXEC) begin
        if (wr_a) bus.o_A <= a_res;
        if (wr_f) bus.o_F <= f_res;
      end
    end
  end

endmodule

// File: doc/misc_alu_exec.md
# misc_alu_exec

Execution end of the CPU's miscellaneous-ALU path: accepts a one-cycle start command from the control-unit microcode and performs DAA, CPL, SCF or CCF on the accumulator and flag register. Operands are latched from the register file, the result is computed, and A and F are written back through registered write strobes. It sits beside the 8-bit ALU, between the microcode sequencer and the register file.

## Interface
Parameters:
- None. Widths are fixed by the SM83 architecture.

Ports:
- i_Clk  in  1  system clock; all state changes on the rising edge
- i_Reset_n  in  1  reset, synchronous and active-low
- i_Start  in  1  command strobe from the microcode; sampled only while o_Ready=1
- i_Op  in  2  operation: 00 DAA, 01 CPL, 10 SCF, 11 CCF
- i_A  in  8  accumulator value, sampled with i_Start
- i_F  in  8  flag register value, sampled with i_Start; bits 7..4 are Z N H C
- o_Ready  out  1  block can accept i_Start this cycle
- o_Done  out  1  one-cycle pulse marking the write-back cycle
- o_WriteA  out  1  write strobe for A; asserted only for DAA and CPL
- o_WriteF  out  1  write strobe for F; asserted for every executed op
- o_A  out  8  result accumulator; valid while o_WriteA=1
- o_F  out  8  result flags; bits 3..0 are always 0

## Operation
- The FSM has three states: IDLE, EXEC and WRITE.
- IDLE: i_Start=1 latches i_Op, i_A and i_F, then moves to EXEC. With no start it stays in IDLE.
- EXEC: computes the result into the output registers, then moves to WRITE unconditionally.
- WRITE: o_Done, o_WriteF and (if applicable) o_WriteA are high for this one cycle. If i_Start=1 in this cycle, new operands are latched and the FSM moves to EXEC (back-to-back). Otherwise it returns to IDLE.
- o_Ready = (state==IDLE) or (state==WRITE).
- i_Start while in EXEC is ignored and not queued.
- DAA, add case (N=0):
  - If C=1 or A>0x99: add 0x60 and set C=1.
  - If H=1 or A[3:0]>9: add 0x06.
  - Both tests use the latched original A. Addition is modulo 256.
- DAA, subtract case (N=1):
  - If C=1: subtract 0x60.
  - If H=1: subtract 0x06.
  - C is unchanged. Subtraction is modulo 256.
- DAA flags: Z=(result==0), N unchanged, H=0.
- CPL: A=~A; N=1, H=1; Z and C unchanged.
- SCF: C=1, N=0, H=0; Z unchanged; A not written.
- CCF: C=~C, N=0, H=0; Z unchanged; A not written.
- Input bits i_F[3:0] are ignored. Output bits o_F[3:0] are forced to 0.

## Timing
- Reset (i_Reset_n=0 at an edge) sets state=IDLE, o_Done=0, o_WriteA=0, o_WriteF=0, o_A=0x00, o_F=0x00. o_Ready reads 1 from the first cycle after reset.
- Latency: i_Start sampled at edge k gives EXEC in cycle k+1 and WRITE (strobes high) in cycle k+2.
- Back-to-back throughput is one operation every 2 cycles.
- Reset mid-operation (in EXEC or WRITE) aborts the operation. No strobe is issued in the following cycle.
- o_A and o_F hold their last values outside WRITE.

## Configuration
- Macro: MISC_ALU_DAA_EN.
- Defined: DAA is implemented as described above.
- Undefined: the DAA adjust logic is not compiled. An op=00 command still runs IDLE→EXEC→WRITE and pulses o_Done, but o_WriteA=0 and o_WriteF=0, so the register file is untouched. CPL, SCF and CCF are unaffected.

## Structure
- Shared package misc_alu_pkg holds:
  - op encodings: OP_DAA, OP_CPL, OP_SCF, OP_CCF
  - flag bit indices: FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4
  - the FSM state enum
- One combinational sub-module, misc_alu_daa_adjust, takes (A, N, H, C) and returns (A', C'). It is instantiated only under MISC_ALU_DAA_EN.

## Test plan
- DAA after BCD add: A=0x3C, F=0x00, op=00 → cycle k+2: o_A=0x42, o_F=0x00, o_WriteA=1, o_WriteF=1, o_Done=1.
- DAA wrap: A=0x9A, F=0x00 → o_A=0x00, o_F=0x90 (Z=1, C=1).
- DAA subtract: A=0x0F, F=0x60 → o_A=0x09, o_F=0x40.
- CPL, SCF, CCF:
  - CPL with A=0x35, F=0x80 → o_A=0xCA, o_F=0xE0.
  - SCF with F=0x60 → o_F=0x10, o_WriteA=0.
  - CCF with F=0x90 → o_F=0x80.
- Back-to-back and ignored start:
  - CPL started, then SCF with i_Start=1 during the CPL's WRITE cycle → two o_Done pulses 2 cycles apart.
  - i_Start asserted during EXEC → no third operation.
- Reset during EXEC: i_Reset_n=0 for one edge → no strobes in the next cycle, o_A=0x00, o_F=0x00, o_Ready=1. With MISC_ALU_DAA_EN undefined, op=00 → o_Done=1 with both write strobes at 0.
